// File: rtl/tl_left_scheduler_pkg.sv
// Shared definitions for the two-street left-turn scheduler.
//   state_t     : phase encoding S0..S7 (bit 2 selects street B, bits 1:0 sub-phase)
//   RED/YEL/GRN/LFT : 2-bit light codes driven on La/Lb
package tl_left_scheduler_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow after left
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow after left
  } state_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [1:0] LFT = 2'b11;

endpackage

// File: rtl/tl_light_dec.sv
// Light decoder: maps the 3-bit phase to the street A / street B light codes.
// Purely combinational, zero latency from state.
//   state : current phase (bit 2 = street B active, bits 1:0 = sub-phase)
//   La    : street A light code
//   Lb    : street B light code
module tl_light_dec
  import tl_left_scheduler_pkg::*;
(
  input  logic [2:0] state,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  logic [1:0] act;

  // The active street shows green/yellow/left; the idle street is always red.
  always_comb begin
    act = YEL;
    case (state[1:0])
      2'b00:   act = GRN;
      2'b10:   act = LFT;
      default: act = YEL;
    endcase
    La = state[2] ? RED : act;
    Lb = state[2] ? act : RED;
  end

endmodule

// File: rtl/tl_left_scheduler.sv
// Timed, sensor-actuated sequencer for a two-street intersection with
// protected left-turn phases. Dwell is counted in ticks of an external enable.
//   clk, reset_n : clock and asynchronous active-low reset
//   tick         : single-cycle dwell enable
//   Ta, Tb       : through-lane car present on street A / B
//   Tal, Tbl     : left-turn car present on street A / B
//   emerg        : (only with TL_EMERG_EN) preempt in favour of street A
//   state        : current phase S0..S7
//   La, Lb       : street A / B light codes
// Optional feature macro: TL_EMERG_EN adds the emerg input.
module tl_left_scheduler
  import tl_left_scheduler_pkg::*;
#(
  parameter int CNT_W     = 5,
  parameter int T_MIN_GRN = 5,
  parameter int T_MAX_GRN = 20,
  parameter int T_YEL     = 3,
  parameter int T_LEFT    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Tal,
  input  logic       Tbl,
`ifdef TL_EMERG_EN
  input  logic       emerg,
`endif
  output logic [2:0] state,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  if (!(T_MIN_GRN >= 1 && T_MIN_GRN <= T_MAX_GRN && T_MAX_GRN < (1 << CNT_W) &&
        T_YEL >= 1 && T_YEL < (1 << CNT_W) && T_LEFT >= 1 && T_LEFT < (1 << CNT_W)))
  begin : g_param_err
    $error("tl_left_scheduler: illegal dwell parameters");
  end

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(T_MIN_GRN - 1);
  localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(T_MAX_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] LEFT_M1  = CNT_W'(T_LEFT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lat_al_q, lat_al_d;
  logic             lat_bl_q, lat_bl_d;

  logic yel_done, left_done, a_grn_exit, b_grn_exit;

  always_comb begin
    yel_done   = tick && (cnt_q == YEL_M1);
    left_done  = tick && (cnt_q == LEFT_M1);
    // Green ends early once the own street is clear after minimum green,
    // or at maximum green if cross demand keeps waiting.
    a_grn_exit = tick && (Tb || lat_bl_q) &&
                 (((cnt_q >= MIN_M1) && !Ta) || (cnt_q >= MAX_M1));
    b_grn_exit = tick && (Ta || lat_al_q) &&
                 (((cnt_q >= MIN_M1) && !Tb) || (cnt_q >= MAX_M1));

    state_d = state_q;
    case (state_q)
      S0: if (a_grn_exit) state_d = S1;
      S1: if (yel_done)   state_d = lat_al_q ? S2 : S4;
      S2: if (left_done)  state_d = S3;
      S3: if (yel_done)   state_d = S4;
      S4: if (b_grn_exit) state_d = S5;
      S5: if (yel_done)   state_d = lat_bl_q ? S6 : S0;
      S6: if (left_done)  state_d = S7;
      S7: if (yel_done)   state_d = S0;
      default:            state_d = S0;
    endcase

`ifdef TL_EMERG_EN
    // Preemption acts without waiting for tick, except that B yellows
    // still run their full dwell before handing back to A.
    if (emerg) begin
      case (state_q)
        S0, S1, S2, S3: state_d = S0;
        S4:             state_d = S5;
        S6:             state_d = S7;
        S5:             if (yel_done) state_d = S0;
        default:        state_d = state_d;
      endcase
    end
`endif

    if (state_d != state_q)
      cnt_d = '0;
    else if (tick && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    // Clear beats set, so a car still waiting re-latches one cycle later.
    if (state_q == S2 && state_d == S3)
      lat_al_d = 1'b0;
    else
      lat_al_d = lat_al_q | Tal;

    if (state_q == S6 && state_d == S7)
      lat_bl_d = 1'b0;
    else
      lat_bl_d = lat_bl_q | Tbl;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S0;
      cnt_q    <= '0;
      lat_al_q <= 1'b0;
      lat_bl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_al_q <= lat_al_d;
      lat_bl_q <= lat_bl_d;
    end
  end

  assign state = state_q;

  tl_light_dec u_dec (
    .state (state_q),
    .La    (La),
    .Lb    (Lb)
  );

endmodule
